// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: sizes,
// requester indices, the request record and small index helpers.
package rf_wb_arbiter_pkg;

  localparam int NREQ = 3;
  localparam int XLEN = 64;

  localparam int REQ_ALU = 0;
  localparam int REQ_MDU = 1;
  localparam int REQ_LSU = 2;

  typedef struct packed {
    logic            valid;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

  // (a + b) mod n for a, b already in [0, n): a single wrap is enough.
  function automatic int f_wrap_add(input int a, input int b, input int n);
    return ((a + b) >= n) ? (a + b - n) : (a + b);
  endfunction

  // One-hot register mask for a 5-bit register index.
  function automatic logic [31:0] f_reg_bit(input logic [4:0] a);
    return 32'h0000_0001 << a;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle between the execution units (master side)
// and the writeback arbiter (slave side).
interface rf_wb_arbiter_if #(
  parameter int NREQ = rf_wb_arbiter_pkg::NREQ,
  parameter int XLEN = rf_wb_arbiter_pkg::XLEN
);
  logic [NREQ-1:0]           wb_valid;
  logic [NREQ-1:0]           wb_ready;
  logic [NREQ-1:0][4:0]      wb_waddr;
  logic [NREQ-1:0][XLEN-1:0] wb_wdata;

  modport master (output wb_valid, output wb_waddr, output wb_wdata, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_waddr, input  wb_wdata, output wb_ready);
endinterface

// File: rtl/rf_wb_pick.sv
// Rotating two-of-N picker. Scans requesters starting at i_rr_ptr; x0
// writes are accepted without taking a port, the first real write takes
// port 0 and the next one to a different register takes port 1.
module rf_wb_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0]      i_valid,
  input  logic [NREQ-1:0][4:0] i_waddr,
  input  logic [PW-1:0]        i_rr_ptr,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_p0_vld,
  output logic [PW-1:0]        o_p0_idx,
  output logic                 o_p1_vld,
  output logic [PW-1:0]        o_p1_idx,
  output logic [PW-1:0]        o_last_idx
);
  import rf_wb_arbiter_pkg::*;

  logic [PW-1:0] w_idx;
  logic [4:0]    w_p0_addr;

  // Scan candidates in rotating order and hand out the two ports.
  always_comb begin
    o_grant   = '0;
    o_p0_vld  = 1'b0;
    o_p0_idx  = '0;
    o_p1_vld  = 1'b0;
    o_p1_idx  = '0;
    w_p0_addr = 5'd0;
    w_idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'(f_wrap_add(int'(i_rr_ptr), k, NREQ));
      if (i_valid[w_idx]) begin
        if (i_waddr[w_idx] == 5'd0) begin
          o_grant[w_idx] = 1'b1;
        end else if (!o_p0_vld) begin
          o_grant[w_idx] = 1'b1;
          o_p0_vld       = 1'b1;
          o_p0_idx       = w_idx;
          w_p0_addr      = i_waddr[w_idx];
        end else if (!o_p1_vld && (i_waddr[w_idx] != w_p0_addr)) begin
          o_grant[w_idx] = 1'b1;
          o_p1_vld       = 1'b1;
          o_p1_idx       = w_idx;
        end else begin
          o_grant[w_idx] = 1'b0;
        end
      end else begin
        o_grant[w_idx] = 1'b0;
      end
    end
  end

  assign o_last_idx = o_p1_vld ? o_p1_idx : o_p0_idx;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: grants up to two writebacks per cycle
// onto two registered write ports, tracks pending destinations in a
// scoreboard and counts cycles in which a request was refused.
module rf_wb_arbiter #(
  parameter int NREQ = rf_wb_arbiter_pkg::NREQ,
  parameter int XLEN = rf_wb_arbiter_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  rf_wb_arbiter_if.slave  wb,
  output logic            rf_bus_0_wen,
  output logic [4:0]      rf_bus_0_waddr,
  output logic [XLEN-1:0] rf_bus_0_wdata,
  output logic            rf_bus_1_wen,
  output logic [4:0]      rf_bus_1_waddr,
  output logic [XLEN-1:0] rf_bus_1_wdata,
  input  logic            sb_set_valid,
  input  logic [4:0]      sb_set_addr,
  output logic [31:0]     sb_busy,
  output logic [31:0]     stall_cnt
);
  import rf_wb_arbiter_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_req_t              w_req [NREQ];
  logic [NREQ-1:0]      w_valid;
  logic [NREQ-1:0][4:0] w_waddr;
  logic [NREQ-1:0]      w_grant;
  logic                 w_p0_vld;
  logic                 w_p1_vld;
  logic [PW-1:0]        w_p0_idx;
  logic [PW-1:0]        w_p1_idx;
  logic [PW-1:0]        w_last_idx;
  logic [31:0]          w_clr_mask;
  logic [31:0]          w_set_mask;
  logic [31:0]          w_busy_nxt;
  logic                 w_stall;

  logic [PW-1:0]        r_rr_ptr;
  logic                 r_wen0;
  logic [4:0]           r_waddr0;
  logic [XLEN-1:0]      r_wdata0;
  logic                 r_wen1;
  logic [4:0]           r_waddr1;
  logic [XLEN-1:0]      r_wdata1;
  logic [31:0]          r_sb_busy;
  logic [31:0]          r_stall_cnt;

  // Gather the interface lanes into request records and picker inputs.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_req[i].valid = wb.wb_valid[i];
      w_req[i].waddr = wb.wb_waddr[i];
      w_req[i].wdata = wb.wb_wdata[i];
      w_valid[i]     = w_req[i].valid;
      w_waddr[i]     = w_req[i].waddr;
    end
  end

  rf_wb_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_valid    (w_valid),
    .i_waddr    (w_waddr),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_p0_vld   (w_p0_vld),
    .o_p0_idx   (w_p0_idx),
    .o_p1_vld   (w_p1_vld),
    .o_p1_idx   (w_p1_idx),
    .o_last_idx (w_last_idx)
  );

  // Accept nothing while reset is held; otherwise ready follows the picker.
  always_comb begin
    if (reset) begin
      wb.wb_ready = '0;
    end else begin
      wb.wb_ready = w_grant;
    end
  end

  assign w_stall = |(wb.wb_valid & ~wb.wb_ready);

  // Scoreboard next state: a set beats a clear to the same register; x0 never pends.
  always_comb begin
    w_clr_mask = (w_p0_vld ? f_reg_bit(w_req[w_p0_idx].waddr) : 32'h0) |
                 (w_p1_vld ? f_reg_bit(w_req[w_p1_idx].waddr) : 32'h0);
    w_set_mask = (sb_set_valid && (sb_set_addr != 5'd0)) ? f_reg_bit(sb_set_addr) : 32'h0;
    w_busy_nxt = ((r_sb_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
  end

  // Round-robin pointer moves past the last port-consuming grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_p0_vld) begin
      r_rr_ptr <= PW'(f_wrap_add(int'(w_last_idx), 1, NREQ));
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  // Write port 0: one-cycle enable per grant, address/data hold when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wen0   <= 1'b0;
      r_waddr0 <= 5'd0;
      r_wdata0 <= '0;
    end else begin
      r_wen0 <= w_p0_vld;
      if (w_p0_vld) begin
        r_waddr0 <= w_req[w_p0_idx].waddr;
        r_wdata0 <= w_req[w_p0_idx].wdata;
      end else begin
        r_waddr0 <= r_waddr0;
        r_wdata0 <= r_wdata0;
      end
    end
  end

  // Write port 1: same behaviour as port 0 for the second grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wen1   <= 1'b0;
      r_waddr1 <= 5'd0;
      r_wdata1 <= '0;
    end else begin
      r_wen1 <= w_p1_vld;
      if (w_p1_vld) begin
        r_waddr1 <= w_req[w_p1_idx].waddr;
        r_wdata1 <= w_req[w_p1_idx].wdata;
      end else begin
        r_waddr1 <= r_waddr1;
        r_wdata1 <= r_wdata1;
      end
    end
  end

  // Scoreboard pending mask register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sb_busy <= 32'h0;
    end else begin
      r_sb_busy <= w_busy_nxt;
    end
  end

  // Saturating count of cycles with at least one refused request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 32'h0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign rf_bus_0_wen   = r_wen0;
  assign rf_bus_0_waddr = r_waddr0;
  assign rf_bus_0_wdata = r_wdata0;
  assign rf_bus_1_wen   = r_wen1;
  assign rf_bus_1_waddr = r_waddr1;
  assign rf_bus_1_wdata = r_wdata1;
  assign sb_busy        = r_sb_busy;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random
// traffic, compared against a cycle-level reference model of the rules.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int N  = NREQ;
  localparam int XL = XLEN;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wen0, wen1;
  logic [4:0]    waddr0, waddr1;
  logic [XL-1:0] wdata0, wdata1;
  logic          sb_set_valid;
  logic [4:0]    sb_set_addr;
  logic [31:0]   sb_busy, stall_cnt;

  rf_wb_arbiter_if #(.NREQ(N), .XLEN(XL)) wb ();

  rf_wb_arbiter #(.NREQ(N), .XLEN(XL)) dut (
    .clock          (clock),
    .reset          (reset),
    .wb             (wb),
    .rf_bus_0_wen   (wen0),
    .rf_bus_0_waddr (waddr0),
    .rf_bus_0_wdata (wdata0),
    .rf_bus_1_wen   (wen1),
    .rf_bus_1_waddr (waddr1),
    .rf_bus_1_wdata (wdata1),
    .sb_set_valid   (sb_set_valid),
    .sb_set_addr    (sb_set_addr),
    .sb_busy        (sb_busy),
    .stall_cnt      (stall_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus for the current cycle
  logic          s_valid [N];
  logic [4:0]    s_addr  [N];
  logic [XL-1:0] s_data  [N];
  logic          s_set;
  logic [4:0]    s_seta;

  // reference model state
  int            m_ptr;
  logic          m_wen0, m_wen1;
  logic [4:0]    m_a0, m_a1;
  logic [XL-1:0] m_d0, m_d1;
  logic [31:0]   m_busy;
  logic [31:0]   m_stall;
  logic [N-1:0]  e_ready;
  int            e_p0, e_p1;
  logic [N-1:0]  obs_ready;

  int pool [8] = '{0, 1, 2, 3, 5, 9, 17, 31};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_wen0 = 1'b0; m_wen1 = 1'b0;
    m_a0 = 5'd0; m_a1 = 5'd0;
    m_d0 = '0; m_d1 = '0;
    m_busy = 32'h0; m_stall = 32'h0;
  endtask

  // Who gets accepted this cycle, visiting requesters from the round-robin start.
  task automatic model_pick();
    int i;
    e_p0 = -1; e_p1 = -1; e_ready = '0;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (s_valid[i]) begin
        if (s_addr[i] == 5'd0) e_ready[i] = 1'b1;
        else if (e_p0 < 0) begin e_p0 = i; e_ready[i] = 1'b1; end
        else if (e_p1 < 0 && s_addr[i] != s_addr[e_p0]) begin e_p1 = i; e_ready[i] = 1'b1; end
      end
    end
  endtask

  // Effect of the clock edge on the visible state.
  task automatic model_commit();
    logic refused;
    refused = 1'b0;
    for (int i = 0; i < N; i++) if (s_valid[i] && !e_ready[i]) refused = 1'b1;
    m_wen0 = (e_p0 >= 0);
    m_wen1 = (e_p1 >= 0);
    if (e_p0 >= 0) begin m_a0 = s_addr[e_p0]; m_d0 = s_data[e_p0]; end
    if (e_p1 >= 0) begin m_a1 = s_addr[e_p1]; m_d1 = s_data[e_p1]; end
    if (e_p1 >= 0) m_ptr = (e_p1 + 1) % N;
    else if (e_p0 >= 0) m_ptr = (e_p0 + 1) % N;
    if (e_p0 >= 0) m_busy[s_addr[e_p0]] = 1'b0;
    if (e_p1 >= 0) m_busy[s_addr[e_p1]] = 1'b0;
    if (s_set && s_seta != 5'd0) m_busy[s_seta] = 1'b1;
    if (refused && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wen0"},   64'(wen0),   64'(m_wen0));
    chk({tag, ".wen1"},   64'(wen1),   64'(m_wen1));
    chk({tag, ".waddr0"}, 64'(waddr0), 64'(m_a0));
    chk({tag, ".waddr1"}, 64'(waddr1), 64'(m_a1));
    chk({tag, ".wdata0"}, 64'(wdata0), 64'(m_d0));
    chk({tag, ".wdata1"}, 64'(wdata1), 64'(m_d1));
    chk({tag, ".busy"},   64'(sb_busy),   64'(m_busy));
    chk({tag, ".stall"},  64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      wb.wb_valid[i] = s_valid[i];
      wb.wb_waddr[i] = s_addr[i];
      wb.wb_wdata[i] = s_data[i];
    end
    sb_set_valid = s_set;
    sb_set_addr  = s_seta;
  endtask

  // One cycle: drive at negedge, check ready, clock, check registered outputs.
  task automatic apply(input string tag, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                       input logic set, input logic [4:0] seta);
    @(negedge clock);
    s_valid[REQ_ALU] = v[0]; s_addr[REQ_ALU] = a0; s_data[REQ_ALU] = d0;
    s_valid[REQ_MDU] = v[1]; s_addr[REQ_MDU] = a1; s_data[REQ_MDU] = d1;
    s_valid[REQ_LSU] = v[2]; s_addr[REQ_LSU] = a2; s_data[REQ_LSU] = d2;
    s_set = set; s_seta = seta;
    drive();
    #1;
    model_pick();
    obs_ready = wb.wb_ready;
    chk({tag, ".ready"}, 64'(obs_ready), 64'(e_ready));
    @(posedge clock);
    #1;
    model_commit();
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    apply(tag, 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0);
  endtask

  initial begin
    logic [4:0] ra [3];
    model_reset();
    // reset held with everything requesting: no acceptance, outputs cleared
    s_valid[0] = 1'b1; s_valid[1] = 1'b1; s_valid[2] = 1'b1;
    s_addr[0] = 5'd1; s_addr[1] = 5'd2; s_addr[2] = 5'd3;
    s_data[0] = 64'h11; s_data[1] = 64'h22; s_data[2] = 64'h33;
    s_set = 1'b1; s_seta = 5'd4;
    drive();
    @(posedge clock);
    #1;
    chk("rst.ready", 64'(wb.wb_ready), 64'h0);
    check_outputs("rst");
    @(negedge clock);
    for (int i = 0; i < N; i++) s_valid[i] = 1'b0;
    s_set = 1'b0;
    drive();
    reset = 1'b0;

    // three requesters, two ports: LSU refused, then served next
    apply("s1a", 3'b111, 5'd5, 5'd6, 5'd7, 64'hAA, 64'hBB, 64'hCC, 1'b0, 5'd0);
    chk("s1a.ready_const", 64'(obs_ready), 64'h3);
    chk("s1a.stall_const", 64'(stall_cnt), 64'h1);
    apply("s1b", 3'b100, 5'd5, 5'd6, 5'd7, 64'hAA, 64'hBB, 64'hCC, 1'b0, 5'd0);
    chk("s1b.ready_const", 64'(obs_ready), 64'h4);
    chk("s1b.waddr0_const", 64'(waddr0), 64'h7);

    // same destination: ALU first, MDU the cycle after
    apply("s2a", 3'b011, 5'd9, 5'd9, 5'd0, 64'h1, 64'h2, 64'h0, 1'b0, 5'd0);
    chk("s2a.ready_const", 64'(obs_ready), 64'h1);
    apply("s2b", 3'b010, 5'd9, 5'd9, 5'd0, 64'h1, 64'h2, 64'h0, 1'b0, 5'd0);
    chk("s2b.wdata0_const", 64'(wdata0), 64'h2);

    // x0 write needs no port: the other two still get both ports
    apply("s3", 3'b111, 5'd4, 5'd8, 5'd0, 64'h44, 64'h88, 64'h1234, 1'b0, 5'd0);
    chk("s3.ready_const", 64'(obs_ready), 64'h7);

    // scoreboard: set beats a same-cycle clear, a later plain write clears
    apply("s4a", 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b1, 5'd3);
    apply("s4b", 3'b001, 5'd3, 5'd0, 5'd0, 64'h33, 64'h0, 64'h0, 1'b1, 5'd3);
    chk("s4b.busy3_const", 64'(sb_busy[3]), 64'h1);
    apply("s4c", 3'b001, 5'd3, 5'd0, 5'd0, 64'h34, 64'h0, 64'h0, 1'b0, 5'd0);
    chk("s4c.busy3_const", 64'(sb_busy[3]), 64'h0);
    apply("s4d", 3'b000, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 1'b1, 5'd0);

    // random traffic with a small address pool to provoke collisions
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) ra[i] = 5'(pool[$urandom_range(0, 7)]);
      apply("rnd", 3'($urandom_range(0, 7)), ra[0], ra[1], ra[2],
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // reset right after a grant: write vanishes immediately and never reappears
    apply("s5a", 3'b011, 5'd10, 5'd11, 5'd0, 64'hDEAD, 64'hBEEF, 64'h0, 1'b1, 5'd12);
    #1;
    reset = 1'b1;
    #1;
    chk("s5.wen0_async", 64'(wen0), 64'h0);
    chk("s5.wen1_async", 64'(wen1), 64'h0);
    chk("s5.busy_async", 64'(sb_busy), 64'h0);
    chk("s5.stall_async", 64'(stall_cnt), 64'h0);
    chk("s5.ready_async", 64'(wb.wb_ready), 64'h0);
    model_reset();
    @(negedge clock);
    for (int i = 0; i < N; i++) s_valid[i] = 1'b0;
    s_set = 1'b0;
    drive();
    reset = 1'b0;
    idle("s5b");
    idle("s5c");

    // saturation: preload the counter at its ceiling, then refuse a request
    idle("s6a");
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    m_stall = 32'hFFFF_FFFF;
    apply("s6b", 3'b111, 5'd5, 5'd6, 5'd7, 64'h5, 64'h6, 64'h7, 1'b0, 5'd0);
    chk("s6b.stall_const", 64'(stall_cnt), 64'hFFFF_FFFF);
    apply("s6c", 3'b111, 5'd5, 5'd5, 5'd5, 64'h5, 64'h6, 64'h7, 1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter NREQ, default 3, SHALL set the number of writeback requesters: 0 ALU, 1 MDU, 2 LSU.
REQ-003 Parameter XLEN, default 64, SHALL set the writeback data width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wb_valid  in  NREQ  per-requester writeback request.
REQ-007 wb_ready  out  NREQ  per-requester accept; combinational from the valids, addresses and internal state.
REQ-008 wb_waddr  in  NREQ x 5  destination register per requester.
REQ-009 wb_wdata  in  NREQ x XLEN  result data per requester.
REQ-010 rf_bus_0_wen / rf_bus_1_wen  out  1  register-file write-port enables.
REQ-011 rf_bus_0_waddr / rf_bus_1_waddr  out  5  write-port addresses.
REQ-012 rf_bus_0_wdata / rf_bus_1_wdata  out  XLEN  write-port data.
REQ-013 sb_set_valid  in  1  issue marks a destination register as pending.
REQ-014 sb_set_addr  in  5  register to mark pending.
REQ-015 sb_busy  out  32  scoreboard pending mask; bit 0 is always 0.
REQ-016 stall_cnt  out  32  saturating count of cycles in which at least one valid request was refused.

Function
REQ-017 A handshake SHALL occur on requester i when wb_valid[i] and wb_ready[i] are both high at a rising edge.
REQ-018 Candidates SHALL be scanned in rotating order rr_ptr, rr_ptr+1, rr_ptr+2 (mod NREQ).
REQ-019 The first eligible candidate SHALL take port 0 and the second SHALL take port 1; at most 2 requests SHALL be granted per cycle.
REQ-020 A valid request with waddr 0 SHALL be granted without consuming a port and SHALL produce no write.
REQ-021 A second candidate whose waddr equals the first granted candidate's waddr SHALL NOT be granted that cycle, and scanning SHALL continue to the next candidate.
REQ-022 On any port-consuming grant, rr_ptr SHALL become (index of the last port-consuming grant + 1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-023 Write-port outputs SHALL be registered, so data handshaken at edge N drives rf_bus_x_* during cycle N+1.
REQ-024 Each wen SHALL be high for exactly one cycle per grant and SHALL be 0 in idle cycles.
REQ-025 waddr/wdata values are don't-care when wen is 0, but SHALL retain their last value when wen is 0.
REQ-026 sb_busy[a] SHALL set at the edge on which sb_set_valid is high with sb_set_addr == a, for a != 0.
REQ-027 sb_busy[a] SHALL clear at the handshake edge of a granted write to a.
REQ-028 When a set and a clear target the same address in the same cycle, the set SHALL win.
REQ-029 sb_set_addr 0 SHALL be ignored.
REQ-030 stall_cnt SHALL increment in any cycle where some wb_valid[i] is high and wb_ready[i] is low, and SHALL saturate at 0xFFFFFFFF.
REQ-031 Register-file read ports are out of scope; the block SHALL NOT drive them.

Reset
REQ-032 While reset is high, the following SHALL be 0: wen on both ports, waddr, wdata, sb_busy, stall_cnt and rr_ptr.
REQ-033 While reset is high, wb_ready SHALL be 0.
REQ-034 A reset asserted mid-operation SHALL discard all in-flight grants; no write SHALL appear after reset deasserts without a new handshake.

Structure
REQ-035 A shared package SHALL hold NREQ, XLEN, the requester index constants (REQ_ALU=0, REQ_MDU=1, REQ_LSU=2) and a wb_req_t struct {valid, waddr, wdata}.
REQ-036 The block SHALL contain one sub-module, rf_wb_pick: a combinational rotating two-of-N picker that takes valids, addresses and rr_ptr, and returns grant indices and port assignment.

Verification
REQ-037 Scenario: rr_ptr=0; ALU→x5=0xAA, MDU→x6=0xBB, LSU→x7=0xCC, all valid. Response: ALU on port 0, MDU on port 1, LSU refused; next cycle wen0 x5=0xAA, wen1 x6=0xBB; rr_ptr=2; LSU granted the following cycle; stall_cnt=1.
REQ-038 Scenario: ALU and MDU both target x9. Response: only ALU granted; MDU granted next cycle; two single-port writes to x9, in order 1 then 2.
REQ-039 Scenario: LSU writes x0 with data 0x1234. Response: wb_ready high, no wen, sb_busy unchanged, port free for another requester in the same cycle.
REQ-040 Scenario: sb_set x3, then ALU write to x3 in the same cycle as a new sb_set x3. Response: sb_busy[3] stays 1; a later write with no set clears it.
REQ-041 Scenario: reset asserted the cycle after a grant. Response: wen drops to 0 asynchronously, sb_busy=0, stall_cnt=0, and no write appears after reset deasserts.
REQ-042 Scenario: force stall_cnt to 0xFFFFFFFF, then refuse a valid request. Response: stall_cnt holds 0xFFFFFFFF.
